// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb -- register file with an issue/writeback scoreboard
//
// Purpose:
//   A DEPTH = 2^ADDR_W entry register file with NUM_RD combinational read
//   ports. Each register has a busy bit: an issue marks the destination as
//   pending, and a writeback clears it. Register 0 always reads 0 and is
//   never busy.
//
// Optional feature:
//   `define REG_FILE_SB_BYPASS_EN to forward a same-cycle writeback to the
//   read ports (data and busy status). Without it, a write becomes visible
//   on the cycle after the edge that stores it.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_wr_en      writeback strobe
//   i_wr_addr    writeback register index
//   i_wr_data    writeback data
//   i_iss_en     issue strobe (marks i_iss_addr as pending)
//   i_iss_addr   destination register of the issuing instruction
//   i_rd_en      per-port read valid (used only for hazard detection)
//   i_rd_addr    packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   o_rd_data    packed read data,      port k at [k*DATA_W +: DATA_W]
//   o_rd_busy    per-port: addressed register has a pending result
//   o_hazard     any enabled read port hits a busy register
//   o_busy_cnt   number of registers currently pending (registered)
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_iss_en,
    input  logic [ADDR_W-1:0]        i_iss_addr,
    input  logic [NUM_RD-1:0]        i_rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_busy,
    output logic                     o_hazard,
    output logic [ADDR_W:0]          o_busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [CNT_W-1:0]  r_busy_cnt;

    logic [DEPTH-1:0]  w_busy_nxt;
    logic [CNT_W-1:0]  w_busy_cnt_nxt;
    logic              w_wr_ok;
    logic              w_iss_ok;

    assign w_wr_ok  = i_wr_en  && (i_wr_addr  != '0);
    assign w_iss_ok = i_iss_en && (i_iss_addr != '0);

    // Clear on writeback first, then set on issue, so a same-cycle issue
    // and writeback to one register leaves it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_wr_en)
            w_busy_nxt[i_wr_addr] = 1'b0;
        if (w_iss_ok)
            w_busy_nxt[i_iss_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // The count is the popcount of the next busy vector, so it tracks the
    // busy bits exactly and can never underflow or drift.
    always_comb begin
        w_busy_cnt_nxt = '0;
        for (int i = 1; i < DEPTH; i++)
            w_busy_cnt_nxt = w_busy_cnt_nxt + CNT_W'(w_busy_nxt[i]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wr_ok)
                r_mem[i_wr_addr] <= i_wr_data;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
        end
    end

    assign o_busy_cnt = r_busy_cnt;

    // Read ports
    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_stored;
            logic              w_byp;

            assign w_addr   = i_rd_addr[k*ADDR_W +: ADDR_W];
            assign w_stored = (w_addr == '0) ? '0 : r_mem[w_addr];

`ifdef REG_FILE_SB_BYPASS_EN
            // Forwarding is gated by reset so the ports read 0 while reset
            // is held, even if a write is being presented.
            assign w_byp = i_rst_n && w_wr_ok && (w_addr == i_wr_addr);
            assign o_rd_data[k*DATA_W +: DATA_W] = w_byp ? i_wr_data : w_stored;
            assign o_rd_busy[k] = w_byp ? (i_iss_en && (i_iss_addr == w_addr))
                                        : r_busy[w_addr];
`else
            assign w_byp = 1'b0;
            assign o_rd_data[k*DATA_W +: DATA_W] = w_stored;
            assign o_rd_busy[k] = r_busy[w_addr] & ~w_byp;
`endif
        end
    endgenerate

    assign o_hazard = |(i_rd_en & o_rd_busy);

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb -- directed self-checking bench for reg_file_sb
// (default parameters: DATA_W=32, ADDR_W=5, NUM_RD=2)
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     hazard;
    logic [ADDR_W:0]          busy_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_iss_en   (iss_en),
        .i_iss_addr (iss_addr),
        .i_rd_en    (rd_en),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_rd_busy  (rd_busy),
        .o_hazard   (hazard),
        .o_busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; iss_en = 1'b0; rd_en = '0;
    endtask

    task automatic setrd(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a0);
        rd_addr = {a1, a0};
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; rd_en = '0; rd_addr = '0;

        // ---- reset state: all addresses read 0, not busy ----
        #2;
        chk("rst_busy_cnt", 64'(busy_cnt), 64'd0);
        chk("rst_hazard",   64'(hazard),   64'd0);
        for (int a = 0; a < 32; a++) begin
            rd_en = 2'b11;
            setrd(ADDR_W'(31 - a), ADDR_W'(a));
            #1;
            chk("rst_rd_data", 64'(rd_data), 64'd0);
            chk("rst_rd_busy", 64'(rd_busy), 64'd0);
            chk("rst_hazard_rd", 64'(hazard), 64'd0);
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;

        // ---- write 5 = DEADBEEF, then read on every port ----
        step();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        idle();
        setrd(5'd5, 5'd5);
        #1;
        chk("wr5_port0", 64'(rd_data[31:0]),  64'hDEADBEEF);
        chk("wr5_port1", 64'(rd_data[63:32]), 64'hDEADBEEF);

        // ---- write to address 0 is discarded ----
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        step();
        idle();
        setrd(5'd0, 5'd0);
        #1;
        chk("wr0_data", 64'(rd_data), 64'd0);
        chk("wr0_cnt",  64'(busy_cnt), 64'd0);

        // ---- issue 7, hazard, then writeback 7 ----
        iss_en = 1'b1; iss_addr = 5'd7;
        step();
        idle();
        rd_en = 2'b01; setrd(5'd0, 5'd7);
        #1;
        chk("iss7_busy",   64'(rd_busy),  64'b01);
        chk("iss7_hazard", 64'(hazard),   64'd1);
        chk("iss7_cnt",    64'(busy_cnt), 64'd1);
        rd_en = 2'b00;
        #1;
        chk("iss7_no_rden", 64'(hazard), 64'd0);
        rd_en = 2'b10; setrd(5'd7, 5'd0);
        #1;
        chk("iss7_port1_hazard", 64'(hazard), 64'd1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        step();
        wr_en = 1'b0;
        rd_en = 2'b11; setrd(5'd7, 5'd7);
        #1;
        chk("wb7_hazard", 64'(hazard),   64'd0);
        chk("wb7_cnt",    64'(busy_cnt), 64'd0);
        chk("wb7_data",   64'(rd_data),  {32'h77, 32'h77});

        // ---- same-cycle issue and writeback to 9: set wins ----
        idle();
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en  = 1'b1; wr_addr  = 5'd9; wr_data = 32'h55;
        step();
        idle();
        setrd(5'd0, 5'd9);
        #1;
        chk("iw9_busy", 64'(rd_busy),  64'b01);
        chk("iw9_data", 64'(rd_data[31:0]), 64'h55);
        chk("iw9_cnt",  64'(busy_cnt), 64'd1);

        // issue to address 0 has no effect
        iss_en = 1'b1; iss_addr = 5'd0;
        step();
        idle();
        #1;
        chk("iss0_cnt",  64'(busy_cnt), 64'd1);
        chk("iss0_busy", 64'(rd_busy[1]), 64'd0);

        // issue to already-busy 9 keeps count
        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        idle();
        #1;
        chk("reiss9_cnt", 64'(busy_cnt), 64'd1);

        // writeback to non-busy 10 writes data, count unchanged
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hCAFE0010;
        step();
        idle();
        setrd(5'd10, 5'd9);
        #1;
        chk("wr10_cnt",  64'(busy_cnt), 64'd1);
        chk("wr10_data", 64'(rd_data[63:32]), 64'hCAFE0010);
        chk("wr10_busy", 64'(rd_busy), 64'b01);

        // clear 9
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        step();
        idle();
        #1;
        chk("wb9_cnt", 64'(busy_cnt), 64'd0);

        // ---- bypass / no-bypass behaviour on address 3 ----
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
        step();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
        setrd(5'd0, 5'd3);
        #1;
`ifdef REG_FILE_SB_BYPASS_EN
        chk("byp_same_cycle", 64'(rd_data[31:0]), 64'hA5A5A5A5);
`else
        chk("byp_same_cycle", 64'(rd_data[31:0]), 64'h11);
`endif
        step();
        idle();
        #1;
        chk("byp_next_cycle", 64'(rd_data[31:0]), 64'hA5A5A5A5);

        // issue and write the same register; busy reported either way
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        iss_en = 1'b1; iss_addr = 5'd3;
        step();
        idle();
        #1;
        chk("iw3_busy", 64'(rd_busy[0]), 64'd1);
        chk("iw3_cnt",  64'(busy_cnt), 64'd1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h34;
        #1;
`ifdef REG_FILE_SB_BYPASS_EN
        chk("wb3_busy_same", 64'(rd_busy[0]), 64'd0);
`else
        chk("wb3_busy_same", 64'(rd_busy[0]), 64'd1);
`endif
        step();
        idle();
        #1;
        chk("wb3_busy_next", 64'(rd_busy[0]), 64'd0);

        // ---- issue 1,2,3 then asynchronous reset mid-cycle ----
        iss_en = 1'b1; iss_addr = 5'd1;
        step();
        iss_addr = 5'd2;
        step();
        iss_addr = 5'd3;
        step();
        idle();
        setrd(5'd2, 5'd1);
        #1;
        chk("pre_rst_cnt",  64'(busy_cnt), 64'd3);
        chk("pre_rst_busy", 64'(rd_busy),  64'b11);
        // present a write and issue, then pull reset between edges
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        iss_en = 1'b1; iss_addr = 5'd6;
        rd_en = 2'b11; setrd(5'd4, 5'd5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt",    64'(busy_cnt), 64'd0);
        chk("arst_busy",   64'(rd_busy),  64'd0);
        chk("arst_hazard", 64'(hazard),   64'd0);
        chk("arst_data",   64'(rd_data),  64'd0);
        step();   // edge while reset held: write/issue discarded
        idle();
        @(negedge clk);
        // release with a write and issue pending for the first edge
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
        iss_en = 1'b1; iss_addr = 5'd8;
        rst_n = 1'b1;
        step();
        idle();
        setrd(5'd6, 5'd4);
        #1;
        chk("post_rst_wr4_lost", 64'(rd_data[31:0]),  64'd0);
        chk("post_rst_wr6",      64'(rd_data[63:32]), 64'h66);
        chk("post_rst_cnt",      64'(busy_cnt), 64'd1);
        setrd(5'd8, 5'd3);
        #1;
        chk("post_rst_busy", 64'(rd_busy), 64'b10);
        chk("post_rst_r3",   64'(rd_data[31:0]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
